// File: rtl/fp_sub_seq_if.sv
// Request/result bundle for the sequential single-precision subtractor.
// The master drives operands and start; the slave returns r with busy/done.
interface fp_sub_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        busy;
    logic        done;

    modport master (output start, a, b, input r, busy, done);
    modport slave  (input start, a, b, output r, busy, done);
endinterface

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor r = a - b.
// Each operation walks IDLE->ALIGN->ADDSUB->NORM->PACK and truncates toward zero.
module fp_sub_seq (
    input  logic         clk,
    input  logic         rst,
    fp_sub_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, PACK} state_t;
    state_t state, state_nx;

    logic [31:0] opa, opb;        // opb already carries the inverted sign of b
    logic        xs, sub;
    logic [7:0]  xe;
    logic [26:0] xm, ym;          // {hidden, fraction, guard, round, sticky}
    logic [27:0] sum;
    logic        rs;
    logic [9:0]  ne;              // two's complement, range -26..256
    logic [23:0] nm;              // {hidden, fraction}; G/R/S dropped since truncation ignores them
    logic [31:0] r_q;
    logic        done_q;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i <= 26; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    // Alignment: the larger magnitude becomes x, y is shifted into the G/R/S window
    logic [30:0] mag_a, mag_b, mx, my;
    logic        swap, sx, sy;
    logic [26:0] sig_x, sig_y, ym_al;
    logic [7:0]  dif;
    logic [53:0] wide;

    always_comb begin
        mag_a = (opa[30:23] == 8'd0) ? 31'd0 : opa[30:0];
        mag_b = (opb[30:23] == 8'd0) ? 31'd0 : opb[30:0];
        swap  = mag_b > mag_a;
        mx    = swap ? mag_b : mag_a;
        my    = swap ? mag_a : mag_b;
        sx    = swap ? opb[31] : opa[31];
        sy    = swap ? opa[31] : opb[31];
        sig_x = {|mx[30:23], mx[22:0], 3'b000};
        sig_y = {|my[30:23], my[22:0], 3'b000};
        dif   = mx[30:23] - my[30:23];
        wide  = {sig_y, 27'd0} >> dif;
        if (dif >= 8'd27)
            ym_al = {26'd0, |sig_y};
        else
            ym_al = {wide[53:28], wide[27] | (|wide[26:0])};
    end

    // Normalisation: carry-out shifts right, otherwise shift left by leading zeros
    logic [4:0]  lz;
    logic [23:0] nm_nx;
    logic [9:0]  ne_nx;

    always_comb begin
        lz = lzc27(sum[26:0]);
        if (sum[27]) begin
            nm_nx = 24'(sum >> 4);
            ne_nx = {2'b00, xe} + 10'd1;
        end else begin
            nm_nx = 24'((sum[26:0] << lz) >> 3);
            ne_nx = {2'b00, xe} - {5'd0, lz};
        end
    end

    logic [31:0] r_nx;

    always_comb begin
        if (!nm[23])
            r_nx = 32'h0000_0000;
        else if ($signed(ne) >= 10'sd255)
            r_nx = {rs, 8'hFF, 23'd0};
        else if ($signed(ne) <= 10'sd0)
            r_nx = {rs, 31'd0};
        else
            r_nx = {rs, ne[7:0], nm[22:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = ALIGN;
            ALIGN:   state_nx = ADDSUB;
            ADDSUB:  state_nx = NORM;
            NORM:    state_nx = PACK;
            PACK:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            xs     <= 1'b0;
            sub    <= 1'b0;
            xe     <= '0;
            xm     <= '0;
            ym     <= '0;
            sum    <= '0;
            rs     <= 1'b0;
            ne     <= '0;
            nm     <= '0;
            r_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    opa <= bus.a;
                    opb <= {~bus.b[31], bus.b[30:0]};
                end
                ALIGN: begin
                    xe  <= mx[30:23];
                    xm  <= sig_x;
                    ym  <= ym_al;
                    xs  <= sx;
                    sub <= sx ^ sy;
                end
                ADDSUB: begin
                    sum <= sub ? ({1'b0, xm} - {1'b0, ym}) : ({1'b0, xm} + {1'b0, ym});
                    rs  <= (sub && (xm == ym)) ? 1'b0 : xs;
                end
                NORM: begin
                    nm <= nm_nx;
                    ne <= ne_nx;
                end
                PACK: begin
                    r_q    <= r_nx;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.r    = r_q;
    assign bus.done = done_q;
    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_fp_sub_seq.sv
// Bench for fp_sub_seq: directed table, back-to-back, reset abort, busy-start
// and random operands against a real-arithmetic truncating reference.
module tb_fp_sub_seq;
    logic clk = 1'b0;
    logic rst;
    fp_sub_seq_if bus ();

    fp_sub_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Exact value of a single (exponent 255 taken as finite, exponent 0 flushed)
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // a - b computed in double (exact for exponent gaps up to 29), then truncated to single
    function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        real         d;
        logic [63:0] bits;
        int          e;
        d = f2r(a) - f2r(b);
        if (d == 0.0) return 32'h0;
        bits = $realtobits(d);
        e = int'(bits[62:52]) - 1023 + 127;
        if (e >= 255) return {bits[63], 8'hFF, 23'd0};
        if (e <= 0)   return {bits[63], 31'd0};
        return {bits[63], e[7:0], bits[51:29]};
    endfunction

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        res = bus.r;
    endtask

    vec_t        tbl[$];
    logic [31:0] res;
    int          lat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        chk("reset r", bus.r, 32'h0);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back('{32'h42C80000, 32'h43480000, 32'hC2C80000}); // 100 - 200
        tbl.push_back('{32'h43960000, 32'h43960000, 32'h00000000}); // 300 - 300
        tbl.push_back('{32'h00000000, 32'h00000000, 32'h00000000}); // 0 - 0
        tbl.push_back('{32'h3F800000, 32'h33800000, 32'h3F7FFFFF}); // 1 - 2^-24
        tbl.push_back('{32'h3F800000, 32'h30800000, 32'h3F7FFFFF}); // 1 - 2^-30
        tbl.push_back('{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000}); // overflow
        tbl.push_back('{32'h00000000, 32'h40400000, 32'hC0400000}); // 0 - 3
        tbl.push_back('{32'h00400000, 32'hC0400000, 32'h40400000}); // denormal - (-3)
        tbl.push_back('{32'h00800000, 32'h00C00000, 32'h80000000}); // underflow
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, res, lat);
            chk($sformatf("table[%0d] r", i), res, tbl[i].e);
            chk($sformatf("table[%0d] latency", i), 32'(lat), 32'd5);
        end

        // back-to-back: next start raised in the done cycle
        begin
            logic [31:0] ba[3], bb[3], be[3];
            int k, cyc, last;
            ba[0] = 32'h42C80000; bb[0] = 32'hC2480000; be[0] = 32'h43160000;
            ba[1] = 32'hC2540000; bb[1] = 32'hC20C0000; be[1] = 32'hC1900000;
            ba[2] = 32'h00000000; bb[2] = 32'hC32B0000; be[2] = 32'h432B0000;
            @(negedge clk);
            bus.start = 1'b1; bus.a = ba[0]; bus.b = bb[0];
            k = 0; cyc = 0; last = 0;
            while (k < 3 && cyc < 40) begin
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                @(negedge clk);
                cyc++;
                if (bus.done) begin
                    chk($sformatf("b2b[%0d] r", k), bus.r, be[k]);
                    chk($sformatf("b2b[%0d] gap", k), 32'(cyc - last), 32'd5);
                    last = cyc;
                    k++;
                    if (k < 3) begin
                        bus.start = 1'b1; bus.a = ba[k]; bus.b = bb[k];
                    end
                end
            end
            chk("b2b results", 32'(k), 32'd3);
        end

        // reset two cycles into an operation
        begin
            int nd;
            @(negedge clk);
            bus.start = 1'b1; bus.a = 32'h42C80000; bus.b = 32'h43480000;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            chk("abort r during rst", bus.r, 32'h0);
            chk("abort busy during rst", {31'd0, bus.busy}, 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            nd = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus.done) nd++;
            end
            chk("abort done count", 32'(nd), 32'd0);
            chk("abort r after", bus.r, 32'h0);
            run_op(32'h42C80000, 32'h43480000, res, lat);
            chk("post-reset r", res, 32'hC2C80000);
            chk("post-reset latency", 32'(lat), 32'd5);
        end

        // start held while busy must be ignored
        begin
            int nd;
            @(negedge clk);
            bus.start = 1'b1; bus.a = 32'h42C80000; bus.b = 32'h43480000;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            nd = 0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (c == 2) begin
                    bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h3F800000;
                end
                if (c == 4) bus.start = 1'b0;
                if (bus.done) begin
                    nd++;
                    chk("busy-start r", bus.r, 32'hC2C80000);
                end
            end
            chk("busy-start done count", 32'(nd), 32'd1);
        end

        // random operands with exponent gap within 20
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ra, rb;
            int ea, eb;
            ea = $urandom_range(1, 255);
            eb = ea + $urandom_range(0, 40) - 20;
            if (eb < 1)   eb = 1;
            if (eb > 255) eb = 255;
            ra = {1'($urandom), 8'(ea), 23'($urandom)};
            rb = {1'($urandom), 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 15) == 0) ra[30:23] = 8'd0;
            if ($urandom_range(0, 15) == 0) rb[30:23] = 8'd0;
            if ($urandom_range(0, 7) == 0)  rb[30:0]  = ra[30:0];
            run_op(ra, rb, res, lat);
            chk($sformatf("rand %h-%h r", ra, rb), res, ref_sub(ra, rb));
            if (lat != 5) chk($sformatf("rand %h-%h latency", ra, rb), 32'(lat), 32'd5);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/fp_sub_seq.md
FP_SUB_SEQ -- requirements
Module: fp_sub_seq

Interface
REQ-001 The module SHALL have no parameters; the format is fixed to IEEE-754 single precision.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled on the rising edge of clk.
REQ-005 a  input  32  minuend, IEEE-754 single.
REQ-006 b  input  32  subtrahend, IEEE-754 single.
REQ-007 r  output  32  result a-b, registered; holds its value until the next result.
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 done  output  1  one-cycle pulse when r is updated.

Function
REQ-010 The FSM SHALL have states IDLE, ALIGN, ADDSUB, NORM and PACK, with one cycle per state.
REQ-011 In IDLE, on an edge with start=1, the module SHALL capture a and b, invert the captured sign of b, set busy=1 and go to ALIGN.
REQ-012 Inputs a and b SHALL be ignored after capture; start SHALL be ignored while busy=1.
REQ-013 ALIGN SHALL perform these steps:
- form 24-bit significands with the hidden bit;
- extend each by 3 low bits (guard, round, sticky);
- shift the smaller-exponent significand right by the exponent difference;
- OR every bit shifted beyond the round position into sticky;
- for a difference of 27 or more, reduce the operand to sticky only.
REQ-014 ADDSUB, same effective sign: the module SHALL add magnitudes, with the result sign equal to the common sign.
REQ-015 ADDSUB, different effective signs: the module SHALL subtract the smaller magnitude from the larger, with the result sign taken from the larger; an exactly zero difference SHALL give +0.
REQ-016 NORM SHALL renormalise in a single cycle:
- on carry-out, shift right 1, keeping sticky, and increment the exponent;
- otherwise shift left by the leading-zero count and decrement the exponent by that count.
REQ-017 PACK SHALL round by truncation (toward zero), dropping the guard, round and sticky bits, then load r, assert done=1 for one cycle, clear busy and return to IDLE.
REQ-018 Operation latency SHALL be exactly 5 cycles: start sampled at edge N produces r valid and done=1 after edge N+4.
REQ-019 A start present in the cycle where done=1 SHALL be accepted at the next edge, which is back-to-back issue with no gap cycle.
REQ-020 Any operand with exponent field 0 SHALL be treated as zero (denormals flushed); a zero result SHALL be encoded as all-zero magnitude.
REQ-021 A zero operand SHALL pass the other operand through, sign-corrected, with no arithmetic error.
REQ-022 A result exponent of 255 or more after normalisation SHALL produce a signed infinity: exponent 255, fraction 0.
REQ-023 A result exponent of 0 or less after normalisation SHALL flush to signed zero.
REQ-024 Inputs with exponent 255 SHALL be processed as ordinary finite values; no NaN is generated.

Reset
REQ-025 While rst=1, the module SHALL hold state=IDLE, r=32'h00000000, busy=0 and done=0, independent of clk.
REQ-026 Assertion of rst mid-operation SHALL abort the operation with no done pulse; r SHALL read 0 afterwards.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL begin a new operation.

Verification
REQ-028 The bench SHALL apply a=0x42C80000 (100), b=0x43480000 (200), start pulse, and require r=0xC2C80000 (-100) with done exactly 5 cycles later.
REQ-029 The bench SHALL issue three operations back-to-back and require each result with one done pulse per result:
- 100 - (-50): a=0x42C80000, b=0xC2480000, require 0x43160000;
- -53 - (-35): a=0xC2540000, b=0xC20C0000, require 0xC1900000;
- 0 - (-171): a=0x00000000, b=0xC32B0000, require 0x432B0000.
REQ-030 The bench SHALL check cancellation and zero cases:
- 300 - 300: 0x43960000 - 0x43960000, require 0x00000000;
- 0 - 0, require 0x00000000.
REQ-031 The bench SHALL check far alignment and truncation:
- 1.0 - 2^-24: 0x3F800000 - 0x33800000, require 0x3F7FFFFF;
- 1.0 - 2^-30: 0x3F800000 - 0x30800000, require 0x3F7FFFFF (sticky path).
REQ-032 The bench SHALL check overflow: 0x7F7FFFFF - 0xFF7FFFFF requires r=0x7F800000.
REQ-033 The bench SHALL assert rst 2 cycles after start, then release it, and require:
- no done pulse and r=0;
- a following 100-200 operation returns 0xC2C80000 on schedule.
REQ-034 The bench SHALL pulse start again while busy=1 and require that it is ignored, with exactly one done pulse.
